wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have MEMreg_valid, input, 1, MEM holds a valid instruction.
REQ-004 SHALL have MEM_ready_go, input, 1, MEM result is complete this cycle.
REQ-005 SHALL have MEMreg_2WB, input, 103, bus {alu_result[31:0], data[31:0], rf_we, res_from_mem, rf_waddr[4:0], pc[31:0]}, MSB first.
REQ-006 SHALL have MEM_ld_op, input, 3, load type: 000 LD.W, 001 LD.B, 010 LD.H, 011 LD.BU, 100 LD.HU, others are treated as LD.W.
REQ-007 SHALL have WB_allow_in, output, 1, WB can accept an instruction this cycle.
REQ-008 SHALL have rf_we / rf_waddr / rf_wdata, output, 1/5/32, register-file write port.
REQ-009 SHALL have WB_fwd, output, 38, {fwd_we, fwd_waddr[4:0], fwd_wdata[31:0]} for ID bypass/hazard detection.
REQ-010 SHALL have debug_wb_pc / debug_wb_rf_we / debug_wb_rf_wnum / debug_wb_rf_wdata, output, 32/4/5/32, trace port.
REQ-011 SHALL have retire_cnt, output, 32, count of instructions retired since reset.

Function
REQ-012 WB_ready_go SHALL be constant 1; WB_allow_in SHALL equal !WB_valid || WB_ready_go.
REQ-013 On a clock edge with MEMreg_valid && MEM_ready_go && WB_allow_in, the stage SHALL latch MEMreg_2WB and MEM_ld_op into internal registers and set WB_valid to 1.
REQ-014 On a clock edge where the capture condition is false, WB_valid SHALL become 0 and the latched registers SHALL hold their values.
REQ-015 Latency SHALL be exactly 1 cycle: a value captured at edge N appears on rf_* and debug_* during cycle N+1.
REQ-016 Load extraction SHALL use the byte offset alu_result[1:0]: B/BU select byte [8*off+7:8*off]; H/HU select halfword alu_result[1] ? [31:16] : [15:0]; W uses the full word.
REQ-017 B and H SHALL sign-extend to 32 bits; BU and HU SHALL zero-extend.
REQ-018 A misaligned offset (H with off[0]=1, W with off!=0) SHALL be ignored; only the stated offset bits select the data.
REQ-019 final_result SHALL be res_from_mem ? extracted load data : alu_result.
REQ-020 rf_we SHALL be WB_valid && latched rf_we; rf_waddr SHALL be the latched rf_waddr; rf_wdata SHALL be final_result.
REQ-021 A write to r0 SHALL still be presented on rf_we; the register file discards it.
REQ-022 WB_fwd SHALL be {rf_we && (rf_waddr != 0), rf_waddr, final_result}.
REQ-023 debug_wb_pc SHALL be the latched pc; debug_wb_rf_we SHALL be {4{rf_we}}; debug_wb_rf_wnum SHALL be rf_waddr; debug_wb_rf_wdata SHALL be final_result.
REQ-024 retire_cnt SHALL increment by 1 on each edge where WB_valid = 1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-025 A MEM instruction with MEM_ready_go = 0 SHALL NOT be captured; the WB bubble leaves rf_we = 0.

Reset
REQ-026 With reset = 1 at a clock edge, the stage SHALL clear WB_valid and retire_cnt to 0 and clear the latched bus and ld_op to 0; reset SHALL take priority over capture.
REQ-027 During and immediately after reset, the stage SHALL drive rf_we = 0, WB_fwd[37] = 0, debug_wb_rf_we = 0, debug_wb_pc = 0, and WB_allow_in = 1.
REQ-028 Reset asserted mid-stream SHALL discard the held instruction with no register-file write.

Structure
REQ-029 The MEM2WB_LEN bus range, WB_FWD_LEN, and the ld_op encodings SHALL be defined in the shared macro header.
REQ-030 Load extraction SHALL be a purely combinational sub-module, ld_extend (inputs rdata, off, ld_op; output 32-bit result).

Verification
REQ-031 Load path: capture with res_from_mem=1, LD.B, data=0x80FF7F01, off=3 -> next cycle rf_wdata=0xFFFFFF80, rf_we=1.
REQ-032 Unsigned halfword: LD.HU, data=0x8001ABCD, off=2 -> rf_wdata=0x00008001; same capture with LD.H -> rf_wdata=0xFFFF8001.
REQ-033 ALU path: res_from_mem=0, alu_result=0x12345678, rf_waddr=5, pc=0x1C000000 -> rf_wdata=0x12345678, debug_wb_rf_we=4'hF, debug_wb_pc=0x1C000000.
REQ-034 Bubble: MEMreg_valid=1, MEM_ready_go=0 for 3 cycles -> rf_we=0 throughout and retire_cnt unchanged.
REQ-035 r0 write: rf_waddr=0, rf_we=1 -> rf_we=1 and WB_fwd[37]=0.
REQ-036 Reset mid-stream after 10 back-to-back retirements -> retire_cnt=10; reset edge -> WB_valid=0, retire_cnt=0, and no write on the following cycle.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg -- shared definitions for the write-back stage.
//   MEM2WB_LEN : width of the MEM->WB pipeline bus
//   WB_FWD_LEN : width of the WB bypass bus {we, waddr, wdata}
//   ld_op_e    : load-type encodings carried alongside the bus
//   mem2wb_t   : field layout of the MEM->WB bus, MSB first
package wb_stage_pkg;

    localparam int MEM2WB_LEN = 103;
    localparam int WB_FWD_LEN = 38;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_H  = 3'b010,
        LD_BU = 3'b011,
        LD_HU = 3'b100
    } ld_op_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] data;
        logic        rf_we;
        logic        res_from_mem;
        logic [4:0]  rf_waddr;
        logic [31:0] pc;
    } mem2wb_t;

endpackage

// File: rtl/wb_stage_ld_extend.sv
// ld_extend -- combinational load-data extraction.
//   rdata  : raw 32-bit word returned by memory
//   off    : byte offset (alu_result[1:0]) of the access
//   ld_op  : load type (unknown codes behave as a full word)
//   result : extracted and sign/zero-extended 32-bit value
// Misaligned halfword/word offsets are not trapped here: only the
// offset bits that matter for the access size select the data.
import wb_stage_pkg::*;

module ld_extend (
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  ld_op,
    output logic [31:0] result
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rdata[8*gi +: 8];
    end

    assign byte_sel = lane[off];
    // Halfword select looks at off[1] only; off[0] is ignored.
    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = rdata;
        case (ld_op)
            LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   result = {24'd0, byte_sel};
            LD_H:    result = {{16{half_sel[15]}}, half_sel};
            LD_HU:   result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage -- pipeline write-back stage.
//   clk, reset         : clock and synchronous active-high reset
//   MEMreg_valid       : MEM holds a valid instruction
//   MEM_ready_go       : MEM result is complete this cycle
//   MEMreg_2WB         : MEM->WB bus (see mem2wb_t)
//   MEM_ld_op          : load type of the MEM instruction
//   WB_allow_in        : WB can accept an instruction this cycle
//   rf_we/waddr/wdata  : register-file write port
//   WB_fwd             : {fwd_we, fwd_waddr, fwd_wdata} bypass to ID
//   debug_wb_*         : trace port
//   retire_cnt         : instructions retired since reset (wraps)
import wb_stage_pkg::*;

module wb_stage (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MEMreg_valid,
    input  logic                  MEM_ready_go,
    input  logic [MEM2WB_LEN-1:0] MEMreg_2WB,
    input  logic [2:0]            MEM_ld_op,
    output logic                  WB_allow_in,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [31:0]           rf_wdata,
    output logic [WB_FWD_LEN-1:0] WB_fwd,
    output logic [31:0]           debug_wb_pc,
    output logic [3:0]            debug_wb_rf_we,
    output logic [4:0]            debug_wb_rf_wnum,
    output logic [31:0]           debug_wb_rf_wdata,
    output logic [31:0]           retire_cnt
);

    logic        wb_valid_reg;
    mem2wb_t     bus_reg;
    logic [2:0]  ld_op_reg;
    logic [31:0] retire_cnt_reg;

    logic        wb_ready_go;
    logic        capture;
    logic [31:0] ld_result;
    logic [31:0] final_result;

    // WB always completes in one cycle, so it never back-pressures.
    assign wb_ready_go = 1'b1;
    assign WB_allow_in = !wb_valid_reg || wb_ready_go;
    assign capture     = MEMreg_valid && MEM_ready_go && WB_allow_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_reg   <= 1'b0;
            bus_reg        <= '0;
            ld_op_reg      <= 3'b000;
            retire_cnt_reg <= 32'd0;
        end else begin
            // Count the instruction leaving WB on this edge.
            if (wb_valid_reg) begin
                retire_cnt_reg <= retire_cnt_reg + 32'd1;
            end
            wb_valid_reg <= capture;
            // Payload holds when nothing is captured; only valid drops.
            if (capture) begin
                bus_reg   <= mem2wb_t'(MEMreg_2WB);
                ld_op_reg <= MEM_ld_op;
            end
        end
    end

    ld_extend u_ld_extend (
        .rdata  (bus_reg.data),
        .off    (bus_reg.alu_result[1:0]),
        .ld_op  (ld_op_reg),
        .result (ld_result)
    );

    assign final_result = bus_reg.res_from_mem ? ld_result : bus_reg.alu_result;

    // Writes to r0 are still presented; only the bypass suppresses them.
    assign rf_we    = wb_valid_reg && bus_reg.rf_we;
    assign rf_waddr = bus_reg.rf_waddr;
    assign rf_wdata = final_result;

    assign WB_fwd = {rf_we && (rf_waddr != 5'd0), rf_waddr, final_result};

    assign debug_wb_pc       = bus_reg.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = final_result;

    assign retire_cnt = retire_cnt_reg;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage -- directed, table-driven bench for wb_stage.
module tb_wb_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         MEMreg_valid;
    logic         MEM_ready_go;
    logic [102:0] MEMreg_2WB;
    logic [2:0]   MEM_ld_op;
    logic         WB_allow_in;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic [37:0]  WB_fwd;
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_we;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;
    logic [31:0]  retire_cnt;

    wb_stage dut (
        .clk               (clk),
        .reset             (reset),
        .MEMreg_valid      (MEMreg_valid),
        .MEM_ready_go      (MEM_ready_go),
        .MEMreg_2WB        (MEMreg_2WB),
        .MEM_ld_op         (MEM_ld_op),
        .WB_allow_in       (WB_allow_in),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .WB_fwd            (WB_fwd),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .retire_cnt        (retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] data;
        logic        we;
        logic        rfm;
        logic [4:0]  waddr;
        logic [31:0] pc;
        logic [2:0]  op;
        logic [31:0] exp_wdata;
        logic        exp_we;
        logic        exp_fwd_we;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    int          n_checks = 0;
    int          n_pass   = 0;
    logic        exp_valid;
    logic [31:0] exp_retire;
    logic [31:0] held_pc;
    logic [31:0] held_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // One clock edge; the expected valid/retire model follows the edge.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            exp_valid  = 1'b0;
            exp_retire = 32'd0;
        end else begin
            exp_retire = exp_retire + {31'd0, exp_valid};
            exp_valid  = MEMreg_valid && MEM_ready_go;
        end
        #1;
    endtask

    task automatic drive(input vec_t v);
        MEMreg_valid = 1'b1;
        MEM_ready_go = 1'b1;
        MEMreg_2WB   = {v.alu, v.data, v.we, v.rfm, v.waddr, v.pc};
        MEM_ld_op    = v.op;
    endtask

    task automatic set_vec(input int i, input logic [31:0] alu, input logic [31:0] data,
                           input logic we, input logic rfm, input logic [4:0] waddr,
                           input logic [31:0] pc, input logic [2:0] op,
                           input logic [31:0] exp_wdata, input logic exp_we,
                           input logic exp_fwd_we);
        vecs[i].alu = alu;   vecs[i].data = data; vecs[i].we = we;
        vecs[i].rfm = rfm;   vecs[i].waddr = waddr; vecs[i].pc = pc;
        vecs[i].op = op;     vecs[i].exp_wdata = exp_wdata;
        vecs[i].exp_we = exp_we; vecs[i].exp_fwd_we = exp_fwd_we;
    endtask

    initial begin
        //         alu           data          we   rfm  wa  pc            op       exp_wdata   we fwd
        set_vec(0,  32'h00000003, 32'h80FF7F01, 1'b1, 1'b1, 4, 32'h1C000010, 3'b001, 32'hFFFFFF80, 1, 1); // LD.B off3
        set_vec(1,  32'h00000102, 32'h8001ABCD, 1'b1, 1'b1, 6, 32'h1C000014, 3'b100, 32'h00008001, 1, 1); // LD.HU off2
        set_vec(2,  32'h00000102, 32'h8001ABCD, 1'b1, 1'b1, 6, 32'h1C000018, 3'b010, 32'hFFFF8001, 1, 1); // LD.H off2
        set_vec(3,  32'h12345678, 32'hAAAAAAAA, 1'b1, 1'b0, 5, 32'h1C000000, 3'b000, 32'h12345678, 1, 1); // ALU
        set_vec(4,  32'hDEADBEEF, 32'h00000000, 1'b1, 1'b0, 0, 32'h1C000020, 3'b000, 32'hDEADBEEF, 1, 0); // r0 write
        set_vec(5,  32'h00000002, 32'h80FF7F01, 1'b1, 1'b1, 7, 32'h1C000024, 3'b011, 32'h000000FF, 1, 1); // LD.BU off2
        set_vec(6,  32'h00000002, 32'h80FF7F01, 1'b1, 1'b1, 7, 32'h1C000028, 3'b001, 32'hFFFFFFFF, 1, 1); // LD.B off2
        set_vec(7,  32'h00000000, 32'h80FF7F01, 1'b1, 1'b1, 8, 32'h1C00002C, 3'b001, 32'h00000001, 1, 1); // LD.B off0
        set_vec(8,  32'h00000003, 32'hCAFEF00D, 1'b1, 1'b1, 9, 32'h1C000030, 3'b000, 32'hCAFEF00D, 1, 1); // LD.W misaligned
        set_vec(9,  32'h00000001, 32'h8001ABCD, 1'b1, 1'b1, 10, 32'h1C000034, 3'b010, 32'hFFFFABCD, 1, 1); // LD.H off1
        set_vec(10, 32'h00000003, 32'h8001ABCD, 1'b1, 1'b1, 11, 32'h1C000038, 3'b100, 32'h00008001, 1, 1); // LD.HU off3
        set_vec(11, 32'h00000001, 32'h12345678, 1'b1, 1'b1, 12, 32'h1C00003C, 3'b101, 32'h12345678, 1, 1); // unknown op
        set_vec(12, 32'h00000010, 32'h00000000, 1'b0, 1'b0, 13, 32'h1C000040, 3'b000, 32'h00000010, 0, 0); // no write

        exp_valid    = 1'b0;
        exp_retire   = 32'd0;
        reset        = 1'b1;
        MEMreg_valid = 1'b1;
        MEM_ready_go = 1'b1;
        MEMreg_2WB   = '1;
        MEM_ld_op    = 3'b001;
        step();
        step();
        // Reset must dominate a pending capture.
        $display("reset: rf_we=%0b pc=0x%08h retire=%0d", rf_we, debug_wb_pc, retire_cnt);
        check("reset_rf_we",     {31'd0, rf_we}, 32'd0);
        check("reset_fwd_we",    {31'd0, WB_fwd[37]}, 32'd0);
        check("reset_dbg_we",    {28'd0, debug_wb_rf_we}, 32'd0);
        check("reset_dbg_pc",    debug_wb_pc, 32'd0);
        check("reset_allow_in",  {31'd0, WB_allow_in}, 32'd1);
        check("reset_retire",    retire_cnt, 32'd0);

        reset = 1'b0;
        MEMreg_valid = 1'b0;
        step();
        check("idle_rf_we", {31'd0, rf_we}, 32'd0);

        // Back-to-back captures from the vector table.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            step();
            $display("vec %0d: op=%0d wdata=0x%08h we=%0b fwd_we=%0b pc=0x%08h retire=%0d",
                     i, vecs[i].op, rf_wdata, rf_we, WB_fwd[37], debug_wb_pc, retire_cnt);
            check($sformatf("v%0d_wdata", i),     rf_wdata, vecs[i].exp_wdata);
            check($sformatf("v%0d_rf_we", i),     {31'd0, rf_we}, {31'd0, vecs[i].exp_we});
            check($sformatf("v%0d_fwd_we", i),    {31'd0, WB_fwd[37]}, {31'd0, vecs[i].exp_fwd_we});
            check($sformatf("v%0d_fwd_waddr", i), {27'd0, WB_fwd[36:32]}, {27'd0, vecs[i].waddr});
            check($sformatf("v%0d_fwd_wdata", i), WB_fwd[31:0], vecs[i].exp_wdata);
            check($sformatf("v%0d_waddr", i),     {27'd0, rf_waddr}, {27'd0, vecs[i].waddr});
            check($sformatf("v%0d_dbg_wnum", i),  {27'd0, debug_wb_rf_wnum}, {27'd0, vecs[i].waddr});
            check($sformatf("v%0d_dbg_we", i),    {28'd0, debug_wb_rf_we}, {28'd0, {4{vecs[i].exp_we}}});
            check($sformatf("v%0d_dbg_pc", i),    debug_wb_pc, vecs[i].pc);
            check($sformatf("v%0d_dbg_wdata", i), debug_wb_rf_wdata, vecs[i].exp_wdata);
            check($sformatf("v%0d_allow_in", i),  {31'd0, WB_allow_in}, 32'd1);
            check($sformatf("v%0d_retire", i),    retire_cnt, exp_retire);
        end

        // Bubble: MEM valid but not ready for 3 cycles; payload must hold.
        drive(vecs[3]);
        step();
        held_pc    = 32'h1C000000;
        held_wdata = 32'h12345678;
        MEM_ready_go = 1'b0;
        MEMreg_2WB   = '1;
        MEM_ld_op    = 3'b001;
        for (int c = 0; c < 3; c++) begin
            step();
            $display("bubble %0d: rf_we=%0b pc=0x%08h retire=%0d", c, rf_we, debug_wb_pc, retire_cnt);
            check($sformatf("bub%0d_rf_we", c),  {31'd0, rf_we}, 32'd0);
            check($sformatf("bub%0d_retire", c), retire_cnt, exp_retire);
            check($sformatf("bub%0d_pc", c),     debug_wb_pc, held_pc);
            check($sformatf("bub%0d_wdata", c),  rf_wdata, held_wdata);
        end
        check("bubble_retire_const", retire_cnt, exp_retire);

        // Reset mid-stream after 10 retirements.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 11; k++) begin
            drive(vecs[3]);
            MEMreg_2WB[31:0] = 32'h1C001000 + 32'(k * 4);
            step();
        end
        $display("stream: retire=%0d rf_we=%0b pc=0x%08h", retire_cnt, rf_we, debug_wb_pc);
        check("stream_retire",  retire_cnt, 32'd10);
        check("stream_rf_we",   {31'd0, rf_we}, 32'd1);
        reset = 1'b1;
        step();
        $display("mid reset: retire=%0d rf_we=%0b pc=0x%08h", retire_cnt, rf_we, debug_wb_pc);
        check("mid_reset_retire",   retire_cnt, 32'd0);
        check("mid_reset_rf_we",    {31'd0, rf_we}, 32'd0);
        check("mid_reset_fwd_we",   {31'd0, WB_fwd[37]}, 32'd0);
        check("mid_reset_dbg_pc",   debug_wb_pc, 32'd0);
        check("mid_reset_allow_in", {31'd0, WB_allow_in}, 32'd1);
        reset = 1'b0;
        MEMreg_valid = 1'b0;
        step();
        $display("post reset: retire=%0d rf_we=%0b", retire_cnt, rf_we);
        check("post_reset_rf_we",  {31'd0, rf_we}, 32'd0);
        check("post_reset_retire", retire_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
